// File: rtl/rs232_rx_frame_if.sv
// Byte handshake between the RS-232 receive stage (master) and its consumer (slave).
// The master presents a byte with its error flags; the slave accepts it on valid_o & ready_i.
interface rs232_rx_frame_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;

  modport master (
    output data_o, valid_o, parity_err_o, frame_err_o, overrun_o,
    input  ready_i
  );

  modport slave (
    input  data_o, valid_o, parity_err_o, frame_err_o, overrun_o,
    output ready_i
  );
endinterface

// File: rtl/rs232_rx_frame.sv
// RS-232 receive stage: synchronises RXD_i, samples each bit at mid-bit and holds the
// received byte with parity/framing/overrun status in a one-entry valid/ready register.
module rs232_rx_frame #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             RXD_i,
  rs232_rx_frame_if.master rx,
  output logic             busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_parErr;
  logic          r_sync1;
  logic          r_sync2;

  logic w_rxd;
  logic w_bitDone;
  logic w_parityBad;

  assign w_rxd       = r_sync2;
  assign w_bitDone   = (r_cnt == LAST_CNT);
  assign w_parityBad = (w_rxd != ((^r_shift) ^ PARITY_ODD));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_bitIdx        <= '0;
      r_shift         <= '0;
      r_parErr        <= 1'b0;
      r_sync1         <= 1'b1;
      r_sync2         <= 1'b1;
      rx.data_o       <= 8'h00;
      rx.valid_o      <= 1'b0;
      rx.parity_err_o <= 1'b0;
      rx.frame_err_o  <= 1'b0;
      rx.overrun_o    <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      r_sync1      <= RXD_i;
      r_sync2      <= r_sync1;
      rx.overrun_o <= 1'b0;
      if (rx.valid_o && rx.ready_i) begin
        rx.valid_o <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (!w_rxd) begin
            r_cnt   <= '0;
            r_state <= START;
            busy_o  <= 1'b1;
          end
        end

        // A start bit that is high again at mid-bit was only a glitch.
        START: begin
          if (r_cnt == HALF_CNT) begin
            r_cnt <= '0;
            if (!w_rxd) begin
              r_bitIdx <= '0;
              r_parErr <= 1'b0;
              r_state  <= DATA;
            end else begin
              r_state <= IDLE;
              busy_o  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DATA: begin
          if (w_bitDone) begin
            r_cnt   <= '0;
            r_shift <= {w_rxd, r_shift[7:1]};
            if (r_bitIdx == 3'd7) begin
              r_state <= PARITY_EN ? PARITY : STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (w_bitDone) begin
            r_cnt    <= '0;
            r_parErr <= w_parityBad;
            r_state  <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Commit overrides the handshake clear, so a same-cycle accept keeps valid_o high.
        STOP: begin
          if (w_bitDone) begin
            r_cnt           <= '0;
            rx.data_o       <= r_shift;
            rx.parity_err_o <= r_parErr;
            rx.frame_err_o  <= ~w_rxd;
            rx.valid_o      <= 1'b1;
            rx.overrun_o    <= rx.valid_o & ~rx.ready_i;
            if (w_rxd) begin
              r_state <= IDLE;
              busy_o  <= 1'b0;
            end else begin
              r_state <= WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (w_rxd) begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rs232_rx_frame.md
# rs232_rx_frame

Upstream receive stage of the RS-232 path. The block synchronises the raw `RXD_i` line and detects the start bit. It samples 8 data bits LSB-first, an optional parity bit and the stop bit at mid-bit, then presents each received byte on a one-entry valid/ready holding register, flagged with parity, framing and overrun status. Downstream, the byte consumer (scan-code decode / transmit path) reads from that register.

## Interface
- `CLKS_PER_BIT`, 5208: clock cycles per bit (50 MHz / 9600 Bd). Legal minimum is 4.
- `PARITY_EN`, 1: 1 = a parity bit follows data bit 7; 0 = the stop bit follows data bit 7 directly.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Ignored when `PARITY_EN`=0.
- `clk_i`  in  1  system clock. Single clock domain.
- `rst_i`  in  1  asynchronous, active-high reset.
- `RXD_i`  in  1  serial line. Asynchronous to `clk_i`. Idles high.
- `data_o`  out  8  received byte.
- `valid_o`  out  1  `data_o` and the error flags hold an unconsumed byte.
- `ready_i`  in  1  consumer accepts the byte when `valid_o & ready_i`.
- `parity_err_o`  out  1  parity mismatch for the held byte. Always 0 when `PARITY_EN`=0.
- `frame_err_o`  out  1  stop bit was sampled 0 for the held byte.
- `overrun_o`  out  1  one-cycle pulse: an unconsumed byte was overwritten.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- Input path: `RXD_i` passes through a 2-flop synchroniser reset to 1. All logic uses the second flop, `rxd_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on `rxd_s`=0, load the bit counter with 0 and go to START.
- START: count to `CLKS_PER_BIT/2 - 1` (integer division), then resample.
  - `rxd_s`=0: clear the counter and go to DATA.
  - `rxd_s`=1: glitch; go to IDLE with no output.
- DATA: after each `CLKS_PER_BIT` cycles, sample into the shift register, LSB first. After bit 7, go to PARITY if `PARITY_EN`, otherwise STOP.
- PARITY: after `CLKS_PER_BIT` cycles, sample `p`.
  - Error when `p != (^data ^ PARITY_ODD)`.
- STOP: after `CLKS_PER_BIT` cycles, sample the stop bit and commit the frame.
  - `data_o`, `parity_err_o` and `frame_err_o` load together, and `valid_o` is set to 1.
  - Stop bit = 1: go to IDLE.
  - Stop bit = 0: set `frame_err_o`=1, still deliver the byte, go to WAIT_HIGH.
- WAIT_HIGH: remain until `rxd_s`=1, then go to IDLE. This stops a break condition from retriggering reception.
- Handshake: `valid_o` clears on the cycle after `valid_o & ready_i`. `data_o` and the flags hold their values until the next commit.
- Commit while `valid_o`=1 and `ready_i`=0:
  - The new byte overwrites the held byte.
  - `overrun_o` pulses for one cycle.
  - `valid_o` stays 1.
- Commit on the same cycle as an accept: the new byte loads, `valid_o` stays 1, and there is no overrun.
- Counter width is `$clog2(CLKS_PER_BIT)` bits. The counter clears on every bit boundary and never wraps mid-bit.

## Timing
- Reset values, asserted asynchronously:
  - state IDLE, counters 0, shift register 0, synchroniser flops 1.
  - `data_o`=8'h00, `valid_o`=0, `parity_err_o`=0, `frame_err_o`=0, `overrun_o`=0, `busy_o`=0.
- Reset mid-frame: the partial frame is discarded and no `valid_o` is produced. After release, the block waits in IDLE for a fresh falling edge.
- Synchroniser latency: 2 cycles from a `RXD_i` edge to `rxd_s`.
- Sample points: start bit at cycle `CLKS_PER_BIT/2` after it is detected; each following bit `CLKS_PER_BIT` cycles later.
- `valid_o` rises on the edge after the stop-bit sample.
- Frame length: 10 bit-times (11 with parity), plus 2 cycles of synchroniser latency and the half-bit offset.

## Test plan
Bench settings for all scenarios: `CLKS_PER_BIT`=5, 20 ns clock (100 ns bit), `PARITY_EN`=1, `PARITY_ODD`=0, and `ready_i`=1 unless stated.
- Send 0x45 with parity 1 and stop 1 -> `data_o`=0x45, `valid_o` high for 1 cycle, all error flags 0.
- Send the bytes 0x45, 0x16, 0x1E, 0x26 back-to-back with 1200 ns idle gaps -> four `valid_o` pulses with the matching data, no errors.
- Send 0x16 with parity 0 -> `data_o`=0x16, `parity_err_o`=1.
- Send 0x1E with the stop bit 0, then hold the line low for 300 ns -> one byte with `frame_err_o`=1; no second frame until the line returns high.
- Drive a low glitch of 40 ns on an idle line -> no `valid_o`, `busy_o` returns to 0 within 5 cycles.
- With `ready_i`=0, send 0x26 then 0x25 -> `overrun_o` pulses once and `data_o`=0x25.
  - Then assert `rst_i` in the middle of a third frame -> all outputs at their reset values and no spurious byte afterwards.
